// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: load/store sequencer between the CPU memory stage and a
// byte-wide, synchronous-read data RAM. A word/half/byte request is split into
// 1, 2 or 4 little-endian byte transactions. Load bytes are gathered into four
// lanes, then sign/zero-extended. Addresses above IO_THRESHOLD bypass the RAM
// and are served from the two IO input words.
module lsu_byte_seq #(
  parameter int          ADDR_W       = 17,
  parameter logic [31:0] IO_THRESHOLD = 32'hBFC00FFF,
  parameter logic [31:0] IO1_ADDR     = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_width,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [7:0]        mem_rdata,
  input  logic [31:0]       ioin1,
  input  logic [31:0]       ioin2
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Request latched at acceptance; request inputs are ignored afterwards.
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  width_q;
  logic        wen_q;
  logic        io_q;

  // Byte index within the current ISSUE phase.
  logic [1:0]  k_q;

  // One-deep read pipeline: the byte requested in cycle c returns in cycle c+1.
  logic        rd_pend_q;
  logic [1:0]  rd_lane_q;
  logic [7:0]  lane_q [4];

  // Last response word, presented on resp_rdata between responses.
  logic [31:0] hold_q;

  logic        accept;
  logic        req_is_io;
  logic [1:0]  last_k;
  logic [31:0] issue_sum;
  logic [31:0] load_word;
  logic [31:0] resp_word;

  // Last byte index for a width code: bytes -> 0, halves -> 1, everything else -> 3.
  function automatic logic [1:0] last_idx(input logic [2:0] w);
    case (w)
      3'b010, 3'b110: last_idx = 2'd0;
      3'b001, 3'b101: last_idx = 2'd1;
      default:        last_idx = 2'd3;
    endcase
  endfunction

  assign accept    = req_valid && (state_q == S_IDLE);
  assign req_is_io = (req_addr > IO_THRESHOLD);
  assign last_k    = last_idx(width_q);
  // 32-bit modular add, then truncated to the RAM address width so an
  // access crossing the top of the RAM wraps to address 0.
  assign issue_sum = addr_q + {30'd0, k_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_is_io ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (k_q == last_k) begin
          state_d = wen_q ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: RAM strobes only in ISSUE, response only in RESP.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    resp_rdata = hold_q;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_ISSUE: begin
        mem_addr  = issue_sum[ADDR_W-1:0];
        mem_wdata = wdata_q[8*k_q +: 8];
        mem_wen   = wen_q;
        mem_ren   = ~wen_q;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = resp_word;
      end
      default: ;
    endcase
  end

  // Latch the request on acceptance and step the byte index through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      width_q <= 3'd0;
      wen_q   <= 1'b0;
      io_q    <= 1'b0;
      k_q     <= 2'd0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      width_q <= req_width;
      wen_q   <= req_wen;
      io_q    <= req_is_io;
      k_q     <= 2'd0;
    end else if (state_q == S_ISSUE) begin
      k_q <= k_q + 2'd1;
    end
  end

  // Track which lane the byte returning next cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_lane_q <= 2'd0;
    end else begin
      rd_pend_q <= (state_q == S_ISSUE) && !wen_q;
      rd_lane_q <= k_q;
    end
  end

  // Per-lane capture of returning read bytes; lanes clear on a new request.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q[gi] <= 8'd0;
      end else if (accept) begin
        lane_q[gi] <= 8'd0;
      end else if (rd_pend_q && (rd_lane_q == 2'(gi))) begin
        lane_q[gi] <= mem_rdata;
      end
    end
  end

  // Format gathered lanes according to the width code.
  always_comb begin
    case (width_q)
      3'b001:  load_word = {{16{lane_q[1][7]}}, lane_q[1], lane_q[0]};
      3'b101:  load_word = {16'd0, lane_q[1], lane_q[0]};
      3'b010:  load_word = {{24{lane_q[0][7]}}, lane_q[0]};
      3'b110:  load_word = {24'd0, lane_q[0]};
      default: load_word = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    endcase
  end

  // Response word: stores return 0, IO loads sample the IO inputs live in RESP.
  always_comb begin
    if (wen_q) begin
      resp_word = 32'd0;
    end else if (io_q) begin
      resp_word = (addr_q == IO1_ADDR) ? ioin1 : ioin2;
    end else begin
      resp_word = load_word;
    end
  end

  // Keep the last response word visible until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 32'd0;
    end else if (state_q == S_RESP) begin
      hold_q <= resp_word;
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed table-driven bench for lsu_byte_seq with a
// byte-wide synchronous-read RAM model, plus hand-written multi-cycle sequences.
module tb_lsu_byte_seq;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wen = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic [2:0]        req_width = 3'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wen;
  logic              mem_ren;
  logic [7:0]        mem_rdata = 8'd0;
  logic [31:0]       ioin1 = 32'hDEADBEEF;
  logic [31:0]       ioin2 = 32'h12345678;

  lsu_byte_seq #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .ioin1(ioin1), .ioin2(ioin2)
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor preload port.
  logic [7:0]        ram [1 << ADDR_W];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [7:0]        pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wen) ram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic        log_wen [16];
  logic        log_ren [16];
  logic [31:0] log_addr[16];
  logic [7:0]  log_wd  [16];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, log strobes per cycle, return latency and response data.
  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] width, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = 32'h0BAD0BAD;
    for (int i = 0; i < 16; i++) begin
      log_wen[i] = 1'b0; log_ren[i] = 1'b0; log_addr[i] = 32'd0; log_wd[i] = 8'd0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_width = width;
    @(posedge clk);
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_addr = 32'h5A5A5A5A; req_wdata = 32'hFFFFFFFF;
        req_width = 3'b111; req_wen = ~wen;
      end
      log_wen[c]  = mem_wen;
      log_ren[c]  = mem_ren;
      log_addr[c] = {{(32-ADDR_W){1'b0}}, mem_addr};
      log_wd[c]   = mem_wdata;
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        break;
      end
    end
    req_wen = 1'b0;
  endtask

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] width, input logic [31:0] exp_rd, input int exp_lat);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.width = width;
    v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    string       nm;

    vecs[0]  = mk(0, 32'h00010000, 32'h0,        3'b000, 32'h11223344, 6);
    vecs[1]  = mk(1, 32'h00010005, 32'hABCD8001, 3'b001, 32'h00000000, 3);
    vecs[2]  = mk(0, 32'h00010005, 32'h0,        3'b001, 32'hFFFF8001, 4);
    vecs[3]  = mk(0, 32'h00010005, 32'h0,        3'b101, 32'h00008001, 4);
    vecs[4]  = mk(0, 32'h00010010, 32'h0,        3'b010, 32'hFFFFFFF0, 3);
    vecs[5]  = mk(0, 32'h00010010, 32'h0,        3'b110, 32'h000000F0, 3);
    vecs[6]  = mk(0, 32'h00010005, 32'h0,        3'b000, 32'h557F8001, 6);
    vecs[7]  = mk(0, 32'h00010000, 32'h0,        3'b001, 32'h00003344, 4);
    vecs[8]  = mk(0, 32'h00010000, 32'h0,        3'b011, 32'h11223344, 6);
    vecs[9]  = mk(0, 32'hBFC00FFF, 32'h0,        3'b000, 32'h04030201, 6);
    vecs[10] = mk(0, 32'hFFFFFFFF, 32'h0,        3'b000, 32'hDEADBEEF, 1);
    vecs[11] = mk(0, 32'hFFFFFFDF, 32'h0,        3'b000, 32'h12345678, 1);
    vecs[12] = mk(0, 32'hBFC01000, 32'h0,        3'b000, 32'h12345678, 1);
    vecs[13] = mk(1, 32'hFFFFFFFF, 32'hCAFEF00D, 3'b000, 32'h00000000, 1);
    vecs[14] = mk(1, 32'h0001FFFE, 32'hA1B2C3D4, 3'b000, 32'h00000000, 5);
    vecs[15] = mk(0, 32'h0001FFFE, 32'h0,        3'b000, 32'hA1B2C3D4, 6);
    vecs[16] = mk(0, 32'h0001FFFF, 32'h0,        3'b001, 32'hFFFFB2C3, 4);
    vecs[17] = mk(1, 32'h00010010, 32'h1234567E, 3'b110, 32'h00000000, 2);
    vecs[18] = mk(0, 32'h00010010, 32'h0,        3'b010, 32'h0000007E, 3);

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'd0;

    // Preload while reset is held.
    preload(17'h10000, 8'h44); preload(17'h10001, 8'h33);
    preload(17'h10002, 8'h22); preload(17'h10003, 8'h11);
    preload(17'h10010, 8'hF0);
    preload(17'h10007, 8'h7F); preload(17'h10008, 8'h55);
    preload(17'h00FFF, 8'h01); preload(17'h01000, 8'h02);
    preload(17'h01001, 8'h03); preload(17'h01002, 8'h04);

    // Reset state.
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    check("rst_mem_addr", {15'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      run_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].width, lat, rd);
      $display("[TB] vec %0d wen=%0d addr=0x%08h width=%03b rdata=0x%08h lat=%0d",
               i, vecs[i].wen, vecs[i].addr, vecs[i].width, rd, lat);
      nm = $sformatf("vec%0d_rdata", i);
      check(nm, rd, vecs[i].exp_rd);
      nm = $sformatf("vec%0d_latency", i);
      check(nm, lat, vecs[i].exp_lat);
    end

    // LW strobe sequence.
    run_req(0, 32'h00010000, 32'h0, 3'b000, lat, rd);
    $display("[TB] seq LW strobes lat=%0d rdata=0x%08h", lat, rd);
    for (int c = 1; c <= 6; c++) begin
      nm = $sformatf("lw_ren_c%0d", c);
      check(nm, {31'd0, log_ren[c]}, (c <= 4) ? 32'd1 : 32'd0);
      nm = $sformatf("lw_wen_c%0d", c);
      check(nm, {31'd0, log_wen[c]}, 32'd0);
      if (c <= 4) begin
        nm = $sformatf("lw_addr_c%0d", c);
        check(nm, log_addr[c], 32'h00010000 + c - 1);
      end
    end
    // Response data holds after the response.
    @(negedge clk);
    check("hold_rdata", resp_rdata, 32'h11223344);
    check("hold_valid", {31'd0, resp_valid}, 32'd0);

    // SH strobe sequence.
    run_req(1, 32'h00010005, 32'hABCD8001, 3'b001, lat, rd);
    $display("[TB] seq SH strobes lat=%0d", lat);
    check("sh_c1", {log_wen[1], log_ren[1], log_addr[1][29:0]}, {2'b10, 30'h00010005});
    check("sh_c1_data", {24'd0, log_wd[1]}, 32'h01);
    check("sh_c2", {log_wen[2], log_ren[2], log_addr[2][29:0]}, {2'b10, 30'h00010006});
    check("sh_c2_data", {24'd0, log_wd[2]}, 32'h80);
    check("sh_c3_strobes", {30'd0, log_wen[3], log_ren[3]}, 32'd0);
    check("sh_lat", lat, 32'd3);

    // IO store: no RAM strobes.
    run_req(1, 32'hFFFFFFFF, 32'h11111111, 3'b000, lat, rd);
    $display("[TB] seq IO SW lat=%0d", lat);
    check("io_sw_lat", lat, 32'd1);
    check("io_sw_strobes", {30'd0, log_wen[1], log_ren[1]}, 32'd0);

    // Wrap store strobe addresses.
    run_req(1, 32'h0001FFFE, 32'h01020304, 3'b000, lat, rd);
    $display("[TB] seq wrap SW lat=%0d", lat);
    for (int c = 1; c <= 4; c++) begin
      logic [31:0] ea;
      logic [7:0]  ed;
      ea = (c == 1) ? 32'h1FFFE : (c == 2) ? 32'h1FFFF : (c == 3) ? 32'h0 : 32'h1;
      ed = 8'(5 - c);
      nm = $sformatf("wrap_addr_c%0d", c);
      check(nm, log_addr[c], ea);
      nm = $sformatf("wrap_data_c%0d", c);
      check(nm, {23'd0, log_wen[c], log_wd[c]}, {23'd0, 1'b1, ed});
    end

    // req_valid held high across two requests.
    begin
      logic [11:0] rdy_seen;
      logic [11:0] rsp_seen;
      rdy_seen = '0;
      rsp_seen = '0;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0001FFFE;
      req_wdata = 32'h0A0B0C0D; req_width = 3'b000;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        rdy_seen[c] = req_ready;
        rsp_seen[c] = resp_valid;
        if (c == 7) begin
          req_valid = 1'b0; req_wen = 1'b0;
        end
      end
      $display("[TB] seq back-to-back ready=%012b resp=%012b", rdy_seen, rsp_seen);
      check("b2b_ready", {20'd0, rdy_seen}, 32'b0000_0100_0000);
      check("b2b_resp", {20'd0, rsp_seen}, 32'b1000_0010_0000);
    end

    // Asynchronous reset during ISSUE of a store at k=1.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h00010020;
    req_wdata = 32'h99887766; req_width = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wen = 1'b0;
    @(negedge clk);
    check("pre_rst_wen", {31'd0, mem_wen}, 32'd1);
    check("pre_rst_addr", {15'd0, mem_addr}, 32'h00010021);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_wen", {31'd0, mem_wen}, 32'd0);
    check("async_rst_addr", {15'd0, mem_addr}, 32'd0);
    check("async_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nm = $sformatf("post_rst_c%0d", c);
      check(nm, {29'd0, req_ready, resp_valid, mem_wen}, 32'b100);
    end
    run_req(0, 32'h00010020, 32'h0, 3'b010, lat, rd);
    $display("[TB] seq post-reset LB rdata=0x%08h lat=%0d", rd, lat);
    check("post_rst_lb_rdata", rd, 32'h00000066);
    check("post_rst_lb_lat", lat, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Load/store initiator between the CPU memory stage and a byte-wide, synchronous-read data RAM port.
- Accepts one word, half or byte request at a time and sequences it into 1, 2 or 4 little-endian byte transactions.
- Assembles and sign/zero-extends load data and returns a single-cycle response.
- Addresses above the IO threshold bypass the RAM and are served from the two IO input words.

Parameters:
ADDR_W, 17, width of mem_addr; byte address truncated to low ADDR_W bits
IO_THRESHOLD, 32'hBFC00FFF, addresses strictly greater are IO
IO1_ADDR, 32'hFFFFFFFF, IO address returning ioin1; every other IO address returns ioin2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept request (high only in IDLE)
req_wen  input  1  1=store, 0=load
req_addr  input  32  byte address, any alignment
req_wdata  input  32  store data, little-endian
req_width  input  3  000 W, 001 H, 010 B, 101 HU, 110 BU; other=W
resp_valid  output  1  one-cycle completion pulse (loads and stores)
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores
mem_addr  output  ADDR_W  byte address to RAM
mem_wdata  output  8  byte write data
mem_wen  output  1  byte write strobe
mem_ren  output  1  byte read strobe
mem_rdata  input  8  read byte, valid the cycle after mem_ren
ioin1  input  32  IO word 1
ioin2  input  32  IO word 2

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0. Reset mid-transfer abandons the transfer; no response; RAM may hold a partial store.
- Byte count N: 1 for 010/110, 2 for 001/101, 4 otherwise, for both loads and stores. Stores ignore the signed/unsigned bit.
- Acceptance: edge where req_valid & req_ready in IDLE. Latch addr, wdata, width and wen. Inputs after acceptance are ignored.
- FSM states:
  - IDLE -> ISSUE for RAM accesses, or IDLE -> RESP for IO accesses.
  - ISSUE lasts exactly N cycles, k=0..N-1. mem_addr = (addr+k)[ADDR_W-1:0], 32-bit modular add. mem_ren=~wen, mem_wen=wen, mem_wdata=wdata byte k.
  - ISSUE -> DRAIN for loads; ISSUE -> RESP for stores.
  - DRAIN: one cycle capturing the last byte; DRAIN -> RESP.
  - RESP: resp_valid=1 for one cycle; RESP -> IDLE.
- Read capture: the byte issued in cycle c is sampled from mem_rdata at the end of cycle c+1 into lane k. Reads are pipelined back-to-back.
- Result formatting:
  - W: lanes 3..0.
  - H: sign of lane1 in bits 31:16.
  - HU: zeros in bits 31:16.
  - B: sign of lane0 in bits 31:8.
  - BU: zeros in bits 31:8.
- resp_rdata is registered and holds its value until the next response.
- Latency from the acceptance edge: load RESP at cycle N+2 (W=6, H=4, B=3); store RESP at cycle N+1; IO RESP at cycle 1.
- IO access: no mem strobes. A load returns ioin1 if addr==IO1_ADDR, else ioin2, sampled in RESP. An IO store is dropped but still gets a response.
- Outside ISSUE, mem_wen=mem_ren=0. Strobes are never asserted in IDLE, DRAIN or RESP.
- No back-pressure on the response. A new request can be accepted the cycle after RESP.
- Misaligned accesses are legal, with no fault. An access crossing the top of the ADDR_W space wraps to 0.

Test Plan:
- RAM[0x10000..3]=44,33,22,11; LW 0x10000 -> mem_ren addrs 0x10000..0x10003 on cycles 1-4; resp_valid on cycle 6 with 0x11223344.
- SH wdata=0xABCD8001 @0x10005 -> cycles 1-2: mem_wen with (0x10005,0x01),(0x10006,0x80); resp cycle 3. LH @0x10005 -> 0xFFFF8001; LHU -> 0x00008001.
- RAM[0x10010]=0xF0: LB -> 0xFFFFFFF0, resp cycle 3; LBU -> 0x000000F0.
- IO: ioin1=0xDEADBEEF, ioin2=0x12345678. LW 0xFFFFFFFF -> 0xDEADBEEF at cycle 1. LW 0xFFFFFFDF -> 0x12345678. SW 0xFFFFFFFF -> no mem_wen, resp cycle 1.
- Wrap: SW 0x1FFFE (ADDR_W=17) -> bytes to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001. req_valid held high -> second request accepted only the cycle after RESP; req_ready=0 throughout.
- Reset: assert rst_n=0 during ISSUE of an SW at k=1 -> mem_wen=0 immediately (async). After release: IDLE, req_ready=1, no resp_valid, and a subsequent LB completes normally.
